instr_fetch_queue: RTL and testbench

//  Instruction fetch sequencer for the 28-bit instruction ROM. Owns the program counter and drives the ROM address.

---
 rtl/instr_fetch_queue.sv | 118 +++++++++++
 tb/tb_instr_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address and queues
// {PC, instruction} pairs in a prefetch FIFO for decode/execute.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   oRomAddress         ROM address (the PC register)
//   iRomInstruction     ROM data, combinational from oRomAddress
//   iFetchEnable        allow new fetches; queue drains regardless
//   iRedirect           branch/jump taken pulse, flushes the queue
//   iRedirectPC         redirect target
//   oInstrValid         queue head valid
//   oInstruction        head instruction (0 when not valid)
//   oInstrPC            head PC (0 when not valid)
//   iInstrReady         consumer takes the head this cycle
//   oQueueCount         entries held (0..DEPTH)
module instr_fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 28,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oRomAddress,
    input  logic [INSTR_W-1:0] iRomInstruction,
    input  logic               iFetchEnable,
    input  logic               iRedirect,
    input  logic [ADDR_W-1:0]  iRedirectPC,
    output logic               oInstrValid,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oInstrPC,
    input  logic               iInstrReady,
    output logic [2:0]         oQueueCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDR_W + INSTR_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     head;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [2:0]        count;
    logic              room;
    logic              pop;
    logic              push;

    // Control state register
    always_ff @(posedge Clock) begin
        if (Reset)
            state <= RUN;
        else
            state <= state_nx;
    end

    // Next-state logic; a redirect always wins
    always_comb begin
        state_nx = state;
        if (iRedirect)
            state_nx = FLUSH;
        else if (!iFetchEnable)
            state_nx = IDLE;
        else
            state_nx = RUN;
    end

    // FLUSH always follows a flush, so the queue is known to be empty
    always_comb begin
        room = (state == FLUSH) | (count < 3'(DEPTH));
    end

    assign pop  = oInstrValid & iInstrReady;
    assign push = iFetchEnable & ~iRedirect & (room | pop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (iRedirect) begin
            // Drop everything queued; a same-cycle pop is simply consumed
            pc     <= iRedirectPC;
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr] <= {pc, iRomInstruction};
    end

    assign head         = mem[rd_ptr];
    assign oRomAddress  = pc;
    assign oQueueCount  = count;
    assign oInstrValid  = (count != 3'd0);
    assign oInstruction = oInstrValid ? head[INSTR_W-1:0] : '0;
    assign oInstrPC     = oInstrValid ? head[EW-1:INSTR_W] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_instr_fetch_queue;

    logic        Clock;
    logic        Reset;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic        iFetchEnable;
    logic        iRedirect;
    logic [15:0] iRedirectPC;
    logic        oInstrValid;
    logic [27:0] oInstruction;
    logic [15:0] oInstrPC;
    logic        iInstrReady;
    logic [2:0]  oQueueCount;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .oRomAddress     (oRomAddress),
        .iRomInstruction (iRomInstruction),
        .iFetchEnable    (iFetchEnable),
        .iRedirect       (iRedirect),
        .iRedirectPC     (iRedirectPC),
        .oInstrValid     (oInstrValid),
        .oInstruction    (oInstruction),
        .oInstrPC        (oInstrPC),
        .iInstrReady     (iInstrReady),
        .oQueueCount     (oQueueCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [27:0] rom(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd40503 + 16'h1234;
        return {a[15:4] ^ 12'h5A3, t};
    endfunction

    always_comb iRomInstruction = rom(oRomAddress);

    typedef struct {
        logic [15:0] pc;
        logic [27:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mpc;
    bit          model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic compare();
        chk("rom_addr", 32'(oRomAddress), 32'(mpc));
        chk("valid", 32'(oInstrValid), 32'(q.size() != 0));
        chk("count", 32'(oQueueCount), 32'(q.size()));
        chk("instr", 32'(oInstruction), q.size() != 0 ? 32'(q[0].ins) : 32'd0);
        chk("instr_pc", 32'(oInstrPC), q.size() != 0 ? 32'(q[0].pc) : 32'd0);
    endtask

    // One clock: check at the negedge, drive, then advance the model at the posedge
    task automatic step(input bit r, input bit fe, input bit rdy,
                        input bit rd, input logic [15:0] rpc);
        bit pop;
        bit push;
        if (model_ok)
            compare();
        Reset        = r;
        iFetchEnable = fe;
        iInstrReady  = rdy;
        iRedirect    = rd;
        iRedirectPC  = rpc;
        @(posedge Clock);
        if (r) begin
            q.delete();
            mpc = 16'd0;
            model_ok = 1;
        end else if (model_ok) begin
            pop  = (q.size() != 0) && rdy;
            push = fe && !rd && ((q.size() < 4) || pop);
            if (rd) begin
                q.delete();
                mpc = rpc;
            end else begin
                if (pop)
                    void'(q.pop_front());
                if (push) begin
                    q.push_back('{pc: mpc, ins: rom(mpc)});
                    mpc = mpc + 16'd1;
                end
            end
        end
        @(negedge Clock);
    endtask

    task automatic do_reset();
        repeat (3) step(1, 1, 1, 0, 16'd0);
    endtask

    initial begin
        // Reset then continuous stream
        do_reset();
        chk("t1_reset_addr", 32'(oRomAddress), 32'h0);
        chk("t1_reset_valid", 32'(oInstrValid), 32'h0);
        chk("t1_reset_count", 32'(oQueueCount), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 16'd0);
            chk("t1_pc", 32'(oInstrPC), 32'(i));
            chk("t1_addr", 32'(oRomAddress), 32'(i + 1));
            chk("t1_instr", 32'(oInstruction), 32'(rom(16'(i))));
        end

        // Fill without consumer, then drain in order
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, 16'd0);
            chk("t2_fill_count", 32'(oQueueCount), 32'(i > 4 ? 4 : i));
        end
        chk("t2_frozen_addr", 32'(oRomAddress), 32'h4);
        for (int i = 0; i < 6; i++) begin
            chk("t2_drain_pc", 32'(oInstrPC), 32'(i));
            step(0, 1, 1, 0, 16'd0);
        end

        // Redirect mid-stream
        do_reset();
        repeat (11) step(0, 1, 1, 0, 16'd0);
        chk("t3_addr_pre", 32'(oRomAddress), 32'd11);
        step(0, 1, 1, 1, 16'd5);
        chk("t3_flush_count", 32'(oQueueCount), 32'h0);
        chk("t3_flush_valid", 32'(oInstrValid), 32'h0);
        chk("t3_target_addr", 32'(oRomAddress), 32'h5);
        step(0, 1, 1, 0, 16'd0);
        chk("t3_valid", 32'(oInstrValid), 32'h1);
        chk("t3_pc", 32'(oInstrPC), 32'h5);
        chk("t3_instr", 32'(oInstruction), 32'(rom(16'd5)));

        // PC wrap
        step(0, 1, 1, 1, 16'hFFFE);
        step(0, 1, 1, 0, 16'd0);
        chk("t4_pc0", 32'(oInstrPC), 32'hFFFE);
        step(0, 1, 1, 0, 16'd0);
        chk("t4_pc1", 32'(oInstrPC), 32'hFFFF);
        step(0, 1, 1, 0, 16'd0);
        chk("t4_pc2", 32'(oInstrPC), 32'h0000);
        step(0, 1, 1, 0, 16'd0);
        chk("t4_pc3", 32'(oInstrPC), 32'h0001);

        // Full queue, pop and redirect together
        do_reset();
        repeat (5) step(0, 1, 0, 0, 16'd0);
        chk("t5_full", 32'(oQueueCount), 32'h4);
        step(0, 1, 1, 1, 16'd20);
        chk("t5_count", 32'(oQueueCount), 32'h0);
        chk("t5_addr", 32'(oRomAddress), 32'd20);
        step(0, 1, 1, 0, 16'd0);
        chk("t5_no_repeat", 32'(oInstrPC), 32'd20);

        // Reset with entries queued
        do_reset();
        repeat (3) step(0, 1, 0, 0, 16'd0);
        chk("t6_pre_count", 32'(oQueueCount), 32'h3);
        step(1, 1, 0, 0, 16'd0);
        chk("t6_count", 32'(oQueueCount), 32'h0);
        chk("t6_valid", 32'(oInstrValid), 32'h0);
        chk("t6_instr", 32'(oInstruction), 32'h0);
        chk("t6_addr", 32'(oRomAddress), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          fe;
            bit          rdy;
            bit          rd;
            logic [15:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ?
                  16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            step(r, fe, rdy, rd, rpc);
        end
        compare();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
